// File: rtl/nn_bus_arbiter_if.sv
// nn_bus_arbiter_if: requester-side handshake and AHB-lite bus signals of the
// NN calculator arbiter, bundled so the arbiter and its environment share one
// definition. The slave modport is the arbiter's view; master is the view of
// the requesters plus the bus slave that surround it.
interface nn_bus_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
);
    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

    // requester side
    logic [NUM_MASTERS-1:0]        m_req;
    logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
    logic [NUM_MASTERS-1:0]        m_write;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS-1:0]        m_gnt;
    logic [NUM_MASTERS-1:0]        m_done;
    logic [DATA_W-1:0]             m_rdata;
    logic                          m_err;
    logic [IDX_W-1:0]              hmaster;

    // shared bus side
    logic [ADDR_W-1:0]             HADDR;
    logic                          HWRITE;
    logic [1:0]                    HTRANS;
    logic [DATA_W-1:0]             HWDATA;
    logic                          HREADY;
    logic [DATA_W-1:0]             HRDATA;
    logic                          HRESP;

    modport slave (
        input  m_req, m_addr, m_write, m_wdata, HREADY, HRDATA, HRESP,
        output m_gnt, m_done, m_rdata, m_err, hmaster,
               HADDR, HWRITE, HTRANS, HWDATA
    );

    modport master (
        output m_req, m_addr, m_write, m_wdata, HREADY, HRDATA, HRESP,
        input  m_gnt, m_done, m_rdata, m_err, hmaster,
               HADDR, HWRITE, HTRANS, HWDATA
    );
endinterface

// File: rtl/nn_bus_arbiter.sv
// nn_bus_arbiter: round-robin arbiter serialising single transfers from
// NUM_MASTERS requesters onto the NN calculator's AHB-lite slave bus.
// Each transfer is a registered grant, one address phase and one data phase
// that may be stretched by HREADY. Completion is signalled by a one-cycle
// m_done pulse carrying m_rdata/m_err back to the winner.
// Optional build macro NN_ARB_TIMEOUT_EN: aborts a data phase with m_err = 1
// after TIMEOUT wait-state cycles; without it the data phase waits forever.
module nn_bus_arbiter #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    nn_bus_arbiter_if.slave    bus
);
    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]       LAST_RST = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       r_last_grant;
    logic [IDX_W-1:0]       r_owner;
    logic [ADDR_W-1:0]      r_addr;
    logic                   r_write;
    logic [DATA_W-1:0]      r_wdata;
    logic [NUM_MASTERS-1:0] r_gnt;
    logic [NUM_MASTERS-1:0] r_done;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_err;

    logic                   w_found;
    logic [IDX_W-1:0]       w_winner;
    logic                   w_capture;
    logic                   w_complete;
    logic                   w_abort;
    logic                   w_timeout;

`ifdef NN_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    // wait-state counter: zero outside DATA, counts DATA cycles with HREADY low
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wait_cnt <= '0;
        end else if (r_state != S_DATA) begin
            r_wait_cnt <= '0;
        end else if (!bus.HREADY) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // the TIMEOUT-th consecutive wait cycle ends the transfer on its edge
    assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // round-robin search: first requester after the last winner, wrapping
    always_comb begin
        int unsigned      v_idx;
        logic [IDX_W-1:0] v_sel;
        w_found  = 1'b0;
        w_winner = '0;
        v_idx    = 0;
        v_sel    = '0;
        for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
            v_idx = 32'(r_last_grant) + off;
            if (v_idx >= NUM_MASTERS) begin
                v_idx = v_idx - NUM_MASTERS;
            end
            v_sel = v_idx[IDX_W-1:0];
            if (!w_found && bus.m_req[v_sel]) begin
                w_found  = 1'b1;
                w_winner = v_sel;
            end
        end
    end

    // next-state and transfer-event decode
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bus.HREADY) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_timeout) begin
                    w_complete  = 1'b1;
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // captured transfer, one-cycle grant/done pulses and returned status
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_last_grant <= LAST_RST;
            r_owner      <= '0;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_gnt        <= '0;
            r_done       <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            if (w_capture) begin
                r_addr  <= bus.m_addr[w_winner*ADDR_W +: ADDR_W];
                r_write <= bus.m_write[w_winner];
                r_wdata <= bus.m_wdata[w_winner*DATA_W +: DATA_W];
                r_owner <= w_winner;
                r_gnt   <= ONE_HOT0 << w_winner;
            end
            if (w_complete) begin
                r_done       <= ONE_HOT0 << r_owner;
                r_rdata      <= (w_abort || r_write) ? '0 : bus.HRDATA;
                r_err        <= w_abort | bus.HRESP;
                r_last_grant <= r_owner;
            end
        end
    end

    assign bus.m_gnt   = r_gnt;
    assign bus.m_done  = r_done;
    assign bus.m_rdata = r_rdata;
    assign bus.m_err   = r_err;
    assign bus.hmaster = r_owner;
    assign bus.HADDR   = r_addr;
    assign bus.HWRITE  = r_write;
    assign bus.HWDATA  = r_wdata;
    assign bus.HTRANS  = (r_state == S_ADDR) ? 2'b10 : 2'b00;
endmodule

// File: doc/nn_bus_arbiter.md
Name: nn_bus_arbiter

Overview:
- Round-robin arbiter sharing the single AHB-lite style slave bus of the NN calculator between NUM_MASTERS requesters (e.g. host bridge, DMA, sequencer).
- Serializes single transfers: registered grant, one address phase, one data phase with wait states.
- Drives the address that the slave decoder resolves into the operand/opcode/result registers (0xFFFEFF00..0xFFFEFF0C) or the default slave.
- Returns read data and error status to the winning master.

Parameters:
- NUM_MASTERS, 3, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 15, maximum wait-state cycles in the data phase (used only with the optional feature).

Ports:
- HCLK  in  1  system clock; all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- m_req  in  NUM_MASTERS  per-master transfer request; held high until the matching m_gnt.
- m_addr  in  NUM_MASTERS*ADDR_W  per-master address, packed with master i at [i*ADDR_W +: ADDR_W].
- m_write  in  NUM_MASTERS  per-master direction (1 = write).
- m_wdata  in  NUM_MASTERS*DATA_W  per-master write data, packed the same way as m_addr.
- m_gnt  out  NUM_MASTERS  one-hot grant; high for exactly the ADDR cycle.
- m_done  out  NUM_MASTERS  one-hot completion pulse; one cycle long.
- m_rdata  out  DATA_W  read data; valid while m_done is high.
- m_err  out  1  error flag; valid while m_done is high.
- hmaster  out  clog2(NUM_MASTERS)  index of the current owner.
- HADDR  out  ADDR_W  bus address; feeds the slave decoder.
- HWRITE  out  1  bus direction.
- HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only.
- HWDATA  out  DATA_W  bus write data.
- HREADY  in  1  slave ready; low inserts a wait state.
- HRDATA  in  DATA_W  slave read data.
- HRESP  in  1  slave error response.

Behaviour:
- Reset: all outputs 0 (HTRANS = 00). State = IDLE. last_grant = NUM_MASTERS-1, so master 0 has first priority.
- States: IDLE, ADDR, DATA.
- IDLE, no request: HTRANS = 00; stay in IDLE.
- IDLE, any m_req high: the winner is the first asserted request searching last_grant+1, last_grant+2, ... with wrap-around. On the clock edge:
  - Capture the winner's addr, write and wdata.
  - Set hmaster and m_gnt[winner].
  - Go to ADDR.
- ADDR (1 cycle): HADDR and HWRITE hold the captured values; HTRANS = 10; m_gnt[winner] = 1. Go to DATA on the next edge.
- DATA: HTRANS = 00; HWDATA = captured wdata; HADDR and HWRITE held.
  - HREADY = 0: remain in DATA.
  - HREADY = 1: on the edge, register m_rdata = HRDATA (0 for writes) and m_err = HRESP; pulse m_done[winner] for the next cycle; set last_grant = winner; go to IDLE.
- The m_done cycle is an IDLE cycle, so arbitration runs in the same cycle.
- Throughput: 3 cycles per zero-wait transfer. Latency from request to done is 3 cycles plus wait states.
- m_req is sampled only in IDLE. A request dropped before its grant is simply not served.
- A master that re-requests right after completion goes behind every other pending master.
- hmaster holds its value from grant until the next grant.
- An asynchronous HRESETn assertion in any state aborts the transfer immediately: no m_done, all outputs cleared, last_grant reset.
- The arbiter does not check addresses. Out-of-window addresses go to the default slave and complete normally.

Optional Feature:
- Macro: NN_ARB_TIMEOUT_EN.
- Defined: a wait counter clears on entering DATA and increments each DATA cycle with HREADY = 0.
  - When the count reaches TIMEOUT with HREADY still low, the transfer is aborted: m_done[winner] pulses, m_err = 1, m_rdata = 0, state goes to IDLE, last_grant is updated.
- Undefined: there is no counter; DATA waits indefinitely, and m_err reflects only HRESP.

Test Plan:
- Reset: HRESETn = 0 with m_req = 3'b111 -> HTRANS = 00, m_gnt = 0, m_done = 0. After release, master 0 is granted first.
- Master 0 writes 0x12345678 to 0xFFFEFF00 with HREADY = 1:
  - Cycle 1: m_gnt = 001, HADDR = 0xFFFEFF00, HTRANS = 10, HWRITE = 1.
  - Cycle 2: HWDATA = 0x12345678.
  - Cycle 3: m_done = 001, m_err = 0.
- m_req = 111 held continuously with zero wait states -> grant order 0, 1, 2, 0, 1, 2; a new m_gnt every 3 cycles.
- Master 2 reads 0xFFFEFF0C with HREADY low for 3 DATA cycles and HRDATA = 0x0000A5A5 -> m_done = 100 three cycles later than the zero-wait case; m_rdata = 0x0000A5A5; hmaster = 2.
- Master 1 accesses 0xFFFEFF10 (default slave) and the slave returns HRESP = 1 -> m_done = 010, m_err = 1. The next grant goes to master 2 if it is requesting.
- With NN_ARB_TIMEOUT_EN and TIMEOUT = 15, HREADY stuck low -> m_done with m_err = 1 after 15 wait cycles, then return to IDLE. Without the macro -> no m_done. Assert HRESETn mid-DATA -> outputs clear, no m_done.
